// File: rtl/port_alloc_stage.sv
// rtl/port_alloc_stage.sv - BLESS-MC registered port allocation ahead of the 4x4 crossbar
// Priority-ordered greedy allocation of free output ports, plus saturating event counters.
module port_alloc_stage #(
  parameter int DATA_W  = 64,
  parameter int PPV_LSB = 0,
  parameter int RANK_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic [RANK_W-1:0] rank_in_0,
  input  logic [RANK_W-1:0] rank_in_1,
  input  logic [RANK_W-1:0] rank_in_2,
  input  logic [RANK_W-1:0] rank_in_3,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [RANK_W-1:0] rank_out_0,
  output logic [RANK_W-1:0] rank_out_1,
  output logic [RANK_W-1:0] rank_out_2,
  output logic [RANK_W-1:0] rank_out_3,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  defl_cnt,
  output logic [CNT_W-1:0]  mc_trunc_cnt
);

  logic [DATA_W-1:0] flit_in [4];
  logic [RANK_W-1:0] rank_in [4];
  logic [DATA_W-1:0] flit_d  [4];
  logic [DATA_W-1:0] flit_q  [4];
  logic [RANK_W-1:0] rank_q  [4];
  logic [3:0]        vld;
  logic [2:0]        defl_n;
  logic [2:0]        trunc_n;
  logic [CNT_W-1:0]  defl_q;
  logic [CNT_W-1:0]  trunc_q;

  assign flit_in[0] = in_0;
  assign flit_in[1] = in_1;
  assign flit_in[2] = in_2;
  assign flit_in[3] = in_3;
  assign rank_in[0] = rank_in_0;
  assign rank_in[1] = rank_in_1;
  assign rank_in[2] = rank_in_2;
  assign rank_in[3] = rank_in_3;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      vld[k] = flit_in[k][DATA_W-1];
    end
  end

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [3:0] lowest_n(input logic [3:0] v, input logic [2:0] n);
    logic [3:0] r;
    logic [2:0] taken;
    r     = 4'b0000;
    taken = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && (taken < n)) begin
        r[i]  = 1'b1;
        taken = taken + 3'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [2:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-2){1'b0}}, n};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Budget reserves one port for every valid flit further down the priority order,
  // which is what guarantees each valid flit at least one port.
  always_comb begin
    logic [3:0] free;
    logic [3:0] ppv;
    logic [3:0] req;
    logic [3:0] apv;
    logic [2:0] later;
    logic [2:0] budget;
    free    = 4'b1111;
    defl_n  = 3'd0;
    trunc_n = 3'd0;
    for (int k = 0; k < 4; k++) begin
      flit_d[k] = flit_in[k];
      ppv       = flit_in[k][PPV_LSB +: 4];
      req       = ppv & free;
      apv       = 4'b0000;
      later     = 3'd0;
      budget    = 3'd0;
      for (int j = 0; j < 4; j++) begin
        if (j > k) later = later + {2'b00, vld[j]};
      end
      if (vld[k]) begin
        budget = popcnt4(free) - later;
        if (req != 4'b0000) begin
          apv = lowest_n(req, budget);
          if ((popcnt4(req) > budget) && (popcnt4(ppv) > 3'd1)) trunc_n = trunc_n + 3'd1;
        end else begin
          apv    = lowest_n(free, 3'd1);
          defl_n = defl_n + 3'd1;
        end
        free = free & ~apv;
      end
      flit_d[k][PPV_LSB +: 4] = apv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        flit_q[k] <= '0;
        rank_q[k] <= '0;
      end
      defl_q  <= '0;
      trunc_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        flit_q[k] <= flit_d[k];
        rank_q[k] <= rank_in[k];
      end
      if (stat_clr) begin
        defl_q  <= '0;
        trunc_q <= '0;
      end else begin
        defl_q  <= sat_add(defl_q, defl_n);
        trunc_q <= sat_add(trunc_q, trunc_n);
      end
    end
  end

  assign out_0        = flit_q[0];
  assign out_1        = flit_q[1];
  assign out_2        = flit_q[2];
  assign out_3        = flit_q[3];
  assign rank_out_0   = rank_q[0];
  assign rank_out_1   = rank_q[1];
  assign rank_out_2   = rank_q[2];
  assign rank_out_3   = rank_q[3];
  assign defl_cnt     = defl_q;
  assign mc_trunc_cnt = trunc_q;

endmodule
